// File: rtl/outputs_sa_writer.sv
// Write-back stage for systolic-array results: packs signed 8-bit elements into
// four 16-bit lanes per 64-bit word and streams the words to SRAM through a small FIFO.
module outputs_sa_writer #(
  parameter int ADR_W      = 16,
  parameter int SRAM_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              outputs_start,
  input  logic [6:0]        out_ch,
  input  logic [7:0]        out_height,
  input  logic [7:0]        out_width,
  input  logic              res_valid,
  input  logic [7:0]        res_data,
  output logic              res_ready,
  output logic              o_sram_wren,
  output logic [ADR_W-1:0]  o_sram_addr,
  output logic [SRAM_W-1:0] o_sram_wdata,
  input  logic              i_sram_gnt,
  output logic              finished_write,
  output logic              busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADR_W-1:0]  base_q, widx_q;
  logic [15:0]       total_q, cnt_q;
  logic [1:0]        lane_q;
  logic [SRAM_W-1:0] pack_q;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     fcount_q;
  logic [SRAM_W-1:0] fifo_mem [FIFO_DEPTH];

  logic              fifo_full, fifo_empty;
  logic              accept, last_elem, push, pop, start_hit;
  logic [15:0]       elem_sext;
  logic [SRAM_W-1:0] merged;
  logic [31:0]       base_prod;
  logic [ADR_W-1:0]  base_calc;
  logic [15:0]       total_calc;

  assign fifo_full  = (fcount_q == FIFO_FULL_CNT);
  assign fifo_empty = (fcount_q == '0);
  assign res_ready  = (state_q == RUN) && !fifo_full;
  assign accept     = res_valid && res_ready;
  assign last_elem  = ((cnt_q + 16'd1) == total_q);
  assign push       = accept && ((lane_q == 2'd3) || last_elem);
  assign pop        = !fifo_empty && i_sram_gnt;
  assign start_hit  = (state_q == IDLE) && outputs_start;
  assign elem_sext  = {{8{res_data[7]}}, res_data};

  // Channel base: each channel occupies height*width elements, four per word.
  assign base_prod  = (32'(out_ch) - 32'd1) * 32'(out_height) * 32'(out_width);
  assign base_calc  = ADR_W'(base_prod >> 2);
  assign total_calc = 16'(out_height) * 16'(out_width);

  // Current element overlays its lane; untouched lanes keep the pack register.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[16*gi +: 16] = (lane_q == 2'(gi)) ? elem_sext : pack_q[16*gi +: 16];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (outputs_start) state_d = (total_calc == 16'd0) ? DONE : RUN;
      RUN:     if (accept && last_elem) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    if (!outputs_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      base_q   <= '0;
      widx_q   <= '0;
      total_q  <= '0;
      cnt_q    <= '0;
      lane_q   <= '0;
      pack_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcount_q <= '0;
    end else begin
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        widx_q <= widx_q + 1'b1;
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcount_q <= fcount_q + 1'b1;
        2'b01:   fcount_q <= fcount_q - 1'b1;
        default: fcount_q <= fcount_q;
      endcase
      if (start_hit) begin
        base_q  <= base_calc;
        total_q <= total_calc;
        widx_q  <= '0;
        cnt_q   <= '0;
        lane_q  <= '0;
        pack_q  <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 16'd1;
        if (push) begin
          lane_q <= '0;
          pack_q <= '0;
        end else begin
          lane_q <= lane_q + 2'd1;
          pack_q <= merged;
        end
      end
    end
  end

  // Word storage has no reset; the empty flag masks stale contents on the output.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wptr_q] <= merged;
  end

  assign o_sram_wren    = !fifo_empty;
  assign o_sram_wdata   = fifo_empty ? '0 : fifo_mem[rptr_q];
  assign o_sram_addr    = base_q + widx_q;
  assign finished_write = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_outputs_sa_writer.sv
// Directed bench for outputs_sa_writer: feeds channels, logs granted writes and
// compares them with hand-derived addresses and packed words.
module tb_outputs_sa_writer;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        outputs_start;
  logic [6:0]  out_ch;
  logic [7:0]  out_height, out_width;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        o_sram_wren;
  logic [15:0] o_sram_addr;
  logic [63:0] o_sram_wdata;
  logic        i_sram_gnt;
  logic        finished_write;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] addr_log [$];
  logic [63:0] data_log [$];
  int          wren_cycles = 0;

  outputs_sa_writer #(.ADR_W(16), .SRAM_W(64), .FIFO_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .outputs_start(outputs_start),
    .out_ch(out_ch), .out_height(out_height), .out_width(out_width),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .o_sram_wren(o_sram_wren), .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
    .i_sram_gnt(i_sram_gnt), .finished_write(finished_write), .busy_o(busy_o)
  );

  always #5 i_clk = ~i_clk;

  // Inputs only change #1 after a rising edge, so the negedge view is what the next edge sees.
  always @(negedge i_clk) begin
    if (o_sram_wren === 1'b1) wren_cycles++;
    if (o_sram_wren === 1'b1 && i_sram_gnt === 1'b1) begin
      addr_log.push_back(o_sram_addr);
      data_log.push_back(o_sram_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [7:0] elem(input int pat, input int i);
    if (pat == 0) return 8'(i);
    return (i % 2 == 0) ? 8'h80 : 8'h7F;
  endfunction

  function automatic logic [63:0] model_word(input int pat, input int k, input int total);
    logic [63:0] w;
    logic [7:0]  e;
    w = '0;
    for (int l = 0; l < 4; l++) begin
      if (4 * k + l < total) begin
        e = elem(pat, 4 * k + l);
        w[16*l +: 16] = {{8{e[7]}}, e};
      end
    end
    return w;
  endfunction

  task automatic start_ch(input int ch, input int h, input int w);
    out_ch        = 7'(ch);
    out_height    = 8'(h);
    out_width     = 8'(w);
    outputs_start = 1'b1;
    step();
  endtask

  // Offers elements back to back; grant is withheld for the first 'stall' cycles.
  task automatic feed(input int pat, input int limit, input int stall, input logic [15:0] base);
    int  idx = 0;
    int  cyc = 0;
    bit  acc;
    while (idx < limit && cyc < 2000) begin
      i_sram_gnt = (cyc >= stall);
      res_valid  = 1'b1;
      res_data   = elem(pat, idx);
      if (stall > 0 && (cyc == stall - 5 || cyc == stall - 1)) begin
        chk("stall_wren",  64'(o_sram_wren), 64'd1);
        chk("stall_addr",  64'(o_sram_addr), 64'(base));
        chk("stall_wdata", o_sram_wdata, 64'h0003_0002_0001_0000);
      end
      if (stall > 0 && cyc == stall - 1)
        chk("stall_full_ready", 64'(res_ready), 64'd0);
      acc = res_ready;
      step();
      if (acc) idx++;
      cyc++;
    end
    chk("feed_timeout", 64'(idx), 64'(limit));
    res_valid  = 1'b0;
    i_sram_gnt = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (finished_write !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    chk("done_reached", 64'(finished_write), 64'd1);
  endtask

  task automatic check_writes(input int mark, input int base, input int total, input int pat);
    int nw = (total + 3) / 4;
    chk("num_writes", 64'(addr_log.size() - mark), 64'(nw));
    for (int k = 0; k < nw; k++) begin
      if (mark + k < addr_log.size()) begin
        chk($sformatf("addr[%0d]", k), 64'(addr_log[mark + k]), 64'(16'(base + k)));
        chk($sformatf("data[%0d]", k), data_log[mark + k], model_word(pat, k, total));
      end
    end
  endtask

  task automatic end_ch();
    step();
    chk("finished_held", 64'(finished_write), 64'd1);
    outputs_start = 1'b0;
    step();
    chk("finished_drop", 64'(finished_write), 64'd0);
    chk("busy_idle",     64'(busy_o),         64'd0);
  endtask

  initial begin
    int          mark;
    int          wc;
    logic [63:0] w;

    i_rstn = 1'b0; outputs_start = 1'b0; out_ch = '0; out_height = '0; out_width = '0;
    res_valid = 1'b0; res_data = '0; i_sram_gnt = 1'b1;
    repeat (3) step();
    chk("rst_ready",    64'(res_ready),      64'd0);
    chk("rst_wren",     64'(o_sram_wren),    64'd0);
    chk("rst_addr",     64'(o_sram_addr),    64'd0);
    chk("rst_wdata",    o_sram_wdata,        64'd0);
    chk("rst_finished", 64'(finished_write), 64'd0);
    chk("rst_busy",     64'(busy_o),         64'd0);
    i_rstn = 1'b1;
    step();

    // ch1, 2x8, ramp data
    mark = addr_log.size();
    start_ch(1, 2, 8);
    chk("t1_busy", 64'(busy_o), 64'd1);
    feed(0, 16, 0, 16'd0);
    wait_done();
    check_writes(mark, 0, 16, 0);
    w = (data_log.size() > mark) ? data_log[mark] : 64'hx;
    chk("t1_word0", w, 64'h0003_0002_0001_0000);
    end_ch();
    $display("T1 ch=1 2x8: %0d writes", addr_log.size() - mark);

    // ch3, 4x8, alternating sign extremes
    mark = addr_log.size();
    start_ch(3, 4, 8);
    feed(1, 32, 0, 16'd16);
    wait_done();
    check_writes(mark, 16, 32, 1);
    w = (data_log.size() > mark) ? data_log[mark] : 64'hx;
    chk("t2_word0", w, 64'h007F_FF80_007F_FF80);
    w = (addr_log.size() > mark + 7) ? 64'(addr_log[mark + 7]) : 64'hx;
    chk("t2_last_addr", w, 64'd23);
    end_ch();
    $display("T2 ch=3 4x8: %0d writes", addr_log.size() - mark);

    // ch1, 3x3: last word partial
    mark = addr_log.size();
    start_ch(1, 3, 3);
    feed(0, 9, 0, 16'd0);
    wait_done();
    check_writes(mark, 0, 9, 0);
    w = (data_log.size() > mark + 2) ? data_log[mark + 2] : 64'hx;
    chk("t3_partial", w, 64'h0000_0000_0000_0008);
    end_ch();
    $display("T3 ch=1 3x3: %0d writes", addr_log.size() - mark);

    // ch2, 2x8 with grant withheld for 10 cycles
    mark = addr_log.size();
    start_ch(2, 2, 8);
    feed(0, 16, 10, 16'd4);
    wait_done();
    check_writes(mark, 4, 16, 0);
    end_ch();
    $display("T4 stall ch=2 2x8: %0d writes", addr_log.size() - mark);

    // reset in the middle of RUN, then restart at a new base
    start_ch(1, 2, 8);
    feed(0, 5, 0, 16'd0);
    outputs_start = 1'b0;
    i_rstn = 1'b0;
    step();
    chk("mid_rst_ready",    64'(res_ready),      64'd0);
    chk("mid_rst_wren",     64'(o_sram_wren),    64'd0);
    chk("mid_rst_addr",     64'(o_sram_addr),    64'd0);
    chk("mid_rst_wdata",    o_sram_wdata,        64'd0);
    chk("mid_rst_finished", 64'(finished_write), 64'd0);
    chk("mid_rst_busy",     64'(busy_o),         64'd0);
    i_rstn = 1'b1;
    step();
    mark = addr_log.size();
    start_ch(2, 2, 8);
    feed(0, 16, 0, 16'd4);
    wait_done();
    check_writes(mark, 4, 16, 0);
    end_ch();
    $display("T5 restart ch=2 2x8: %0d writes", addr_log.size() - mark);

    // zero-size channel
    wc = wren_cycles;
    start_ch(1, 0, 8);
    chk("t6_done", 64'(finished_write), 64'd1);
    step();
    step();
    chk("t6_hold", 64'(finished_write), 64'd1);
    chk("t6_no_wren", 64'(wren_cycles - wc), 64'd0);
    end_ch();
    $display("T6 zero-size: wren cycles %0d", wren_cycles - wc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
